unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_latency_counter.sv | 38 +++
 rtl/unified_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
//   state_t  : arbiter FSM states
//   owner_t  : which requester owns the transaction in flight
//   SIZE_*   : access-size encodings used on mem_size / ram_size
//   CNT_W    : width of the latency and starvation counters (covers 1..15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_latency_counter.sv
// Down-counter that times the RAM read latency.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value loaded on load
//   dec        : decrement by one (holds at zero)
//   zero       : count is zero, or reaches zero with this cycle's decrement
module arb_latency_counter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Looking one decrement ahead lets the owner act in the same cycle the
  // count expires instead of one cycle later.
  assign zero = (count == '0) | (dec & (count == WIDTH'(1)));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a fetch port (IF) and a data port (MEM) onto one single-port
// RAM with a fixed read latency. Data requests win unless the fetch side has
// already lost STARVE_LIMIT consecutive grants.
//   clk, reset                 : clock, synchronous active-high reset
//   if_req/if_addr/if_flush    : fetch request, byte address, squash
//   if_rdata/if_ack/if_stall   : fetched word, completion pulse, stall
//   mem_req/mem_write/mem_size : data request, store flag, access size
//   mem_addr/mem_wdata         : data address and store data
//   mem_rdata/mem_ack/mem_stall: load data, completion pulse, stall
//   ram_en/ram_we/ram_size     : RAM issue strobe, write enable, size
//   ram_addr/ram_wdata/ram_rdata: RAM address, write data, read data
//   busy                       : a transaction is in progress
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_stall,
  output logic        ram_en,
  output logic        ram_we,
  output logic [1:0]  ram_size,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAT_VAL    = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  owner_t           owner_q;
  logic             write_q;
  logic             flushed_q;
  logic [CNT_W-1:0] starve_q;

  logic cnt_load, cnt_dec, cnt_zero;
  logic if_ok, grant_if, grant_mem, in_idle, capture;

  arb_latency_counter #(.WIDTH(CNT_W)) u_lat_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(LAT_VAL),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  // A fetch squashed in the same cycle is not eligible for a grant.
  assign if_ok     = if_req & ~if_flush;
  assign in_idle   = (state_q == ST_IDLE);
  assign grant_if  = in_idle & if_ok & (~mem_req | (starve_q == STARVE_MAX));
  assign grant_mem = in_idle & mem_req & ~grant_if;
  assign capture   = (state_q == ST_WAIT) & cnt_zero;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    if_ack   = 1'b0;
    mem_ack  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_if || grant_mem) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        ram_en   = ~reset;
        ram_we   = ~reset & write_q;
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A flush that lands in DONE still suppresses the fetch ack.
        if_ack  = ~reset & (owner_q == OWN_IF) & ~flushed_q & ~if_flush;
        mem_ack = ~reset & (owner_q == OWN_MEM);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;
  assign busy      = ~in_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      write_q   <= 1'b0;
      flushed_q <= 1'b0;
      starve_q  <= '0;
      ram_size  <= 2'b00;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state_q <= state_d;

      if (in_idle) begin
        flushed_q <= 1'b0;
        if (grant_mem) begin
          owner_q   <= OWN_MEM;
          write_q   <= mem_write;
          ram_size  <= mem_size;
          ram_addr  <= mem_addr;
          ram_wdata <= mem_wdata;
        end else if (grant_if) begin
          owner_q   <= OWN_IF;
          write_q   <= 1'b0;
          ram_size  <= SIZE_WORD;
          ram_addr  <= if_addr;
          ram_wdata <= '0;
        end
      end else if ((owner_q == OWN_IF) && if_flush) begin
        flushed_q <= 1'b1;
      end

      if (capture) begin
        if ((owner_q == OWN_MEM) && !write_q) mem_rdata <= ram_rdata;
        if ((owner_q == OWN_IF) && !flushed_q && !if_flush) if_rdata <= ram_rdata;
      end

      // Counts data grants that jumped ahead of a waiting fetch.
      if (!if_req || grant_if) begin
        starve_q <= '0;
      end else if (grant_mem && (starve_q != STARVE_MAX)) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter. Three instances (latency 2, 1 and 15) share
// the same stimulus; a transaction-level model per instance predicts, from
// grant time and latency alone, every cycle's outputs.
module tb_unified_mem_arbiter;

  localparam int N      = 3;
  localparam int STARVE = 4;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, if_req, if_flush, mem_req, mem_write;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [1:0]  mem_size;

  logic [31:0] o_if_rdata [N];
  logic [31:0] o_mem_rdata[N];
  logic [31:0] o_ram_addr [N];
  logic [31:0] o_ram_wdata[N];
  logic [1:0]  o_ram_size [N];
  logic        o_if_ack   [N];
  logic        o_if_stall [N];
  logic        o_mem_ack  [N];
  logic        o_mem_stall[N];
  logic        o_ram_en   [N];
  logic        o_ram_we   [N];
  logic        o_busy     [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    unified_mem_arbiter #(
      .MEM_LATENCY (lat_of(g)),
      .STARVE_LIMIT(STARVE)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_flush (if_flush),
      .if_rdata (o_if_rdata[g]),
      .if_ack   (o_if_ack[g]),
      .if_stall (o_if_stall[g]),
      .mem_req  (mem_req),
      .mem_write(mem_write),
      .mem_size (mem_size),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(o_mem_rdata[g]),
      .mem_ack  (o_mem_ack[g]),
      .mem_stall(o_mem_stall[g]),
      .ram_en   (o_ram_en[g]),
      .ram_we   (o_ram_we[g]),
      .ram_size (o_ram_size[g]),
      .ram_addr (o_ram_addr[g]),
      .ram_wdata(o_ram_wdata[g]),
      .ram_rdata(ram_rdata),
      .busy     (o_busy[g])
    );
  end

  // Reference model: a transaction granted in cycle g issues at g+1,
  // captures read data at g+1+L and acknowledges at g+2+L.
  bit          m_active [N];
  int          m_grant  [N];
  bit          m_mem    [N];
  bit          m_we     [N];
  bit          m_flushed[N];
  int          m_starve [N];
  logic [31:0] m_addr   [N];
  logic [31:0] m_wdata  [N];
  logic [1:0]  m_size   [N];
  logic [31:0] m_if_rd  [N];
  logic [31:0] m_mem_rd [N];

  int cyc;
  int n_checks;
  int n_pass;
  bit running;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic model_clear(input int i);
    m_active[i]  = 1'b0;
    m_grant[i]   = 0;
    m_mem[i]     = 1'b0;
    m_we[i]      = 1'b0;
    m_flushed[i] = 1'b0;
    m_starve[i]  = 0;
    m_addr[i]    = '0;
    m_wdata[i]   = '0;
    m_size[i]    = 2'b00;
    m_if_rd[i]   = '0;
    m_mem_rd[i]  = '0;
  endtask

  always @(negedge clk) begin
    if (running) begin
      for (int i = 0; i < N; i++) begin
        int    lat;
        bit    idle_now, in_issue, in_done, e_if_ack, e_mem_ack, if_wins;
        string sfx;
        lat      = lat_of(i);
        sfx      = $sformatf("[L%0d]", lat);
        idle_now = !m_active[i];
        in_issue = m_active[i] && (cyc == m_grant[i] + 1);
        in_done  = m_active[i] && (cyc == m_grant[i] + 2 + lat);
        if (m_active[i] && !m_mem[i] && if_flush) m_flushed[i] = 1'b1;
        e_if_ack  = in_done && !m_mem[i] && !m_flushed[i] && !reset;
        e_mem_ack = in_done && m_mem[i] && !reset;

        check({"busy", sfx},      32'(o_busy[i]),      32'(m_active[i]));
        check({"ram_en", sfx},    32'(o_ram_en[i]),    32'(in_issue && !reset));
        check({"ram_we", sfx},    32'(o_ram_we[i]),    32'(in_issue && m_we[i] && !reset));
        check({"ram_addr", sfx},  o_ram_addr[i],       m_addr[i]);
        check({"ram_size", sfx},  32'(o_ram_size[i]),  32'(m_size[i]));
        check({"ram_wdata", sfx}, o_ram_wdata[i],      m_wdata[i]);
        check({"if_ack", sfx},    32'(o_if_ack[i]),    32'(e_if_ack));
        check({"mem_ack", sfx},   32'(o_mem_ack[i]),   32'(e_mem_ack));
        check({"if_stall", sfx},  32'(o_if_stall[i]),  32'(if_req && !e_if_ack));
        check({"mem_stall", sfx}, 32'(o_mem_stall[i]), 32'(mem_req && !e_mem_ack));
        check({"if_rdata", sfx},  o_if_rdata[i],       m_if_rd[i]);
        check({"mem_rdata", sfx}, o_mem_rdata[i],      m_mem_rd[i]);

        // Advance the model across the coming clock edge.
        if (reset) begin
          model_clear(i);
        end else begin
          if (m_active[i] && (cyc == m_grant[i] + 1 + lat)) begin
            if (m_mem[i] && !m_we[i]) m_mem_rd[i] = ram_rdata;
            if (!m_mem[i] && !m_flushed[i]) m_if_rd[i] = ram_rdata;
          end
          if (in_done) m_active[i] = 1'b0;
          if_wins = 1'b0;
          if (idle_now) begin
            if_wins = if_req && !if_flush && (!mem_req || m_starve[i] == STARVE);
            if (if_wins) begin
              m_active[i] = 1'b1; m_grant[i] = cyc; m_mem[i] = 1'b0; m_we[i] = 1'b0;
              m_flushed[i] = 1'b0; m_addr[i] = if_addr; m_size[i] = 2'b10; m_wdata[i] = '0;
            end else if (mem_req) begin
              m_active[i] = 1'b1; m_grant[i] = cyc; m_mem[i] = 1'b1; m_we[i] = mem_write;
              m_flushed[i] = 1'b0; m_addr[i] = mem_addr; m_size[i] = mem_size;
              m_wdata[i] = mem_wdata;
              if (if_req) m_starve[i] = (m_starve[i] + 1 > STARVE) ? STARVE : m_starve[i] + 1;
            end
          end
          if (!if_req || if_wins) m_starve[i] = 0;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset    = 1'b0;
    if_req   = 1'b0;
    if_flush = 1'b0;
    mem_req  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    for (int i = 0; i < N; i++) model_clear(i);
    idle_inputs();
    reset = 1'b1;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_size = 2'b00; ram_rdata = '0;
    running = 1'b1;
    repeat (2) tick();

    // Single fetch from 0x10 returning 0x00500093.
    reset = 1'b0;
    if_addr = 32'h10; ram_rdata = 32'h0050_0093;
    if_req = 1'b1; tick();
    if_req = 1'b0; repeat (20) tick();

    // Store and fetch raised together: store goes first.
    mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF; mem_size = 2'b10; mem_write = 1'b1;
    mem_req = 1'b1; if_req = 1'b1; tick();
    mem_req = 1'b0; repeat (5) tick();
    if_req = 1'b0; repeat (40) tick();

    // Both requesters held: fetch must break through after STARVE data grants.
    mem_write = 1'b0; ram_rdata = 32'h1234_5678;
    mem_req = 1'b1; if_req = 1'b1; repeat (120) tick();
    idle_inputs(); repeat (20) tick();

    // Flush during the wait of a fetch.
    if_addr = 32'h80; ram_rdata = 32'hCAFE_F00D;
    if_req = 1'b1; tick();
    if_req = 1'b0; tick();
    if_flush = 1'b1; tick();
    if_flush = 1'b0; repeat (20) tick();

    // Reset in the middle of a fetch.
    ram_rdata = 32'h0BAD_0BAD;
    if_req = 1'b1; tick();
    if_req = 1'b0; tick();
    reset = 1'b1; tick();
    reset = 1'b0; repeat (20) tick();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) == 0) if_req = ~if_req;
      if ($urandom_range(3) == 0) mem_req = ~mem_req;
      if_flush  = ($urandom_range(9) == 0);
      reset     = ($urandom_range(199) == 0);
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_size  = 2'($urandom_range(2));
      mem_write = 1'($urandom_range(1));
      ram_rdata = $urandom;
      tick();
    end

    idle_inputs(); repeat (30) tick();
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
